// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl: 4-way set-associative tag/valid controller.
//
// A request is latched in IDLE, compared against the four ways of its set in
// LOOKUP, and answered from RESP. On a miss a victim way is chosen, a refill is
// requested from memory (MREQ), and the tag is installed when the refill
// completes (MWAIT). The per-set tree-PLRU trees live outside this block: it
// selects one via plru_index, reads its state on plru_state and updates it with
// plru_touch/plru_access.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; req_tag, req_index
//   flush                         invalidate every line (IDLE only)
//   resp_valid/resp_ready         response handshake; resp_hit, resp_way
//   mem_req_valid/mem_req_ready   refill request; mem_req_tag, mem_req_index
//   mem_resp_valid                refill-complete pulse
//   plru_index, plru_state        tree selection and its current 3-bit state
//   plru_access, plru_touch       way touched and the one-cycle update strobe
module cache_way_ctrl #(
  parameter int NUM_SETS = 16,
  parameter int TAG_W = 8,
  localparam int INDEX_W = $clog2(NUM_SETS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [INDEX_W-1:0] req_index,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_hit,
  output logic [1:0]         resp_way,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [TAG_W-1:0]   mem_req_tag,
  output logic [INDEX_W-1:0] mem_req_index,
  input  logic               mem_resp_valid,
  output logic [INDEX_W-1:0] plru_index,
  input  logic [2:0]         plru_state,
  output logic [1:0]         plru_access,
  output logic               plru_touch
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MREQ, MWAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic [TAG_W-1:0]   tag_reg;
  logic [INDEX_W-1:0] index_reg;
  logic [1:0]         victim_reg;
  logic               resp_hit_reg;
  logic [1:0]         resp_way_reg;
  logic [3:0]         valid_reg [NUM_SETS];

  logic               accept;
  logic               install;
  logic [3:0]         hit_vec;
  logic               hit;
  logic [1:0]         hit_way;
  logic [1:0]         victim;
  logic [3:0]         set_valid;

  assign accept  = req_valid && req_ready;
  assign install = (state_reg == MWAIT) && mem_resp_valid && !rst;

  // One tag RAM per way. The read is registered on request acceptance so the
  // stored tags are ready during the single LOOKUP cycle. Installs happen only
  // in MWAIT, so a read and a write never target the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_way
      logic [TAG_W-1:0] tag_mem [NUM_SETS];
      logic [TAG_W-1:0] rd_q;

      always_ff @(posedge clk) begin
        if (install && victim_reg == 2'(gi)) begin
          tag_mem[index_reg] <= tag_reg;
        end
        if (accept) begin
          rd_q <= tag_mem[req_index];
        end
      end

      assign hit_vec[gi] = valid_reg[index_reg][gi] && (rd_q == tag_reg);
    end
  endgenerate

  assign hit = |hit_vec;

  always_comb begin
    hit_way = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (hit_vec[i]) hit_way = 2'(i);
    end
  end

  // Victim: lowest-numbered invalid way; when the set is full, follow the tree.
  // The descending loop lets the lowest invalid way overwrite higher ones.
  always_comb begin
    set_valid = valid_reg[index_reg];
    if (plru_state[2]) victim = plru_state[0] ? 2'd0 : 2'd1;
    else               victim = plru_state[1] ? 2'd2 : 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!set_valid[i]) victim = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    plru_touch    = 1'b0;
    plru_access   = 2'd0;
    case (state_reg)
      IDLE: begin
        req_ready = !flush;
        if (!flush && req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          plru_touch  = 1'b1;
          plru_access = hit_way;
          state_next  = RESP;
        end else begin
          state_next = MREQ;
        end
      end
      MREQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = MWAIT;
      end
      MWAIT: begin
        if (mem_resp_valid) begin
          plru_touch  = 1'b1;
          plru_access = victim_reg;
          state_next  = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // The trees must never be updated while this block is being reset.
    if (rst) begin
      plru_touch  = 1'b0;
      plru_access = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg      <= '0;
      index_reg    <= '0;
      victim_reg   <= 2'd0;
      resp_hit_reg <= 1'b0;
      resp_way_reg <= 2'd0;
    end else begin
      if (accept) begin
        tag_reg   <= req_tag;
        index_reg <= req_index;
      end
      if (state_reg == LOOKUP) begin
        if (hit) begin
          resp_hit_reg <= 1'b1;
          resp_way_reg <= hit_way;
        end else begin
          victim_reg <= victim;
        end
      end
      if (install) begin
        resp_hit_reg <= 1'b0;
        resp_way_reg <= victim_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_reg == IDLE && flush)) begin
      for (int i = 0; i < NUM_SETS; i++) valid_reg[i] <= 4'd0;
    end else if (install) begin
      valid_reg[index_reg][victim_reg] <= 1'b1;
    end
  end

  assign resp_hit      = resp_hit_reg;
  assign resp_way      = resp_way_reg;
  assign mem_req_tag   = tag_reg;
  assign mem_req_index = index_reg;
  assign plru_index    = index_reg;

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Testbench for cache_way_ctrl: directed scenarios followed by randomized
// requests, checked against a behavioural cache model kept in the bench. The
// bench also stands in for the external tree-PLRU trees.
module tb_cache_way_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_tag;
  logic [3:0] req_index;
  logic       flush;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_hit;
  logic [1:0] resp_way;
  logic       mem_req_valid;
  logic       mem_req_ready;
  logic [7:0] mem_req_tag;
  logic [3:0] mem_req_index;
  logic       mem_resp_valid;
  logic [3:0] plru_index;
  logic [2:0] plru_state;
  logic [1:0] plru_access;
  logic       plru_touch;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cache_way_ctrl #(.NUM_SETS(16), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_index(req_index),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_tag(mem_req_tag), .mem_req_index(mem_req_index),
    .mem_resp_valid(mem_resp_valid),
    .plru_index(plru_index), .plru_state(plru_state),
    .plru_access(plru_access), .plru_touch(plru_touch)
  );

  // Tree PLRU: bit2 says which half holds the victim (1 = ways 0/1),
  // bit0 picks within ways 0/1 (1 = way 0), bit1 within ways 2/3 (1 = way 2).
  // Touching a way points every node on its path away from it.
  function automatic logic [2:0] plru_upd(input logic [2:0] s, input logic [1:0] w);
    logic [2:0] r;
    r = s;
    if (w < 2) begin r[2] = 1'b0; r[0] = (w == 2'd1); end
    else       begin r[2] = 1'b1; r[1] = (w == 2'd3); end
    return r;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] s);
    if (s[2]) return s[0] ? 2'd0 : 2'd1;
    return s[1] ? 2'd2 : 2'd3;
  endfunction

  // Stand-in for the external trees: strobe registered, state updated a cycle later.
  logic       plru_clr;
  logic [2:0] env_plru [16];
  logic       touch_q;
  logic [1:0] acc_q;
  logic [3:0] idx_q;
  int         touch_cnt = 0;

  assign plru_state = env_plru[plru_index];

  always @(posedge clk) begin
    if (plru_clr) begin
      for (int i = 0; i < 16; i++) env_plru[i] <= 3'd0;
      touch_q <= 1'b0;
      acc_q   <= 2'd0;
      idx_q   <= 4'd0;
    end else begin
      touch_q <= plru_touch;
      acc_q   <= plru_access;
      idx_q   <= plru_index;
      if (touch_q) env_plru[idx_q] <= plru_upd(env_plru[idx_q], acc_q);
    end
    if (plru_touch) touch_cnt <= touch_cnt + 1;
  end

  // Reference model of cache contents.
  logic [3:0] m_valid [16];
  logic [7:0] m_tag   [16][4];
  logic [2:0] m_plru  [16];
  logic       last_hit;
  logic [1:0] last_way;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 4'd0;
  endtask

  // One full request, starting and ending at a negedge with the DUT in IDLE.
  task automatic do_req(input logic [7:0] t, input logic [3:0] ix,
                        input int mstall, input int rstall, input int wdly);
    logic       eh;
    logic       found;
    logic [1:0] ew;
    int         tc0;
    eh = 1'b0;
    ew = 2'd0;
    for (int w = 0; w < 4; w++) begin
      if (m_valid[ix][w] && m_tag[ix][w] == t) begin eh = 1'b1; ew = 2'(w); end
    end
    if (!eh) begin
      found = 1'b0;
      for (int w = 0; w < 4; w++) begin
        if (!found && !m_valid[ix][w]) begin found = 1'b1; ew = 2'(w); end
      end
      if (!found) ew = plru_victim(m_plru[ix]);
    end
    tc0 = touch_cnt;

    req_valid = 1'b1; req_tag = t; req_index = ix;
    #1;
    check("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_tag = 8'($urandom); req_index = 4'($urandom);
    @(negedge clk);
    check("lookup_touch", 32'(plru_touch), 32'(eh));
    if (eh) check("lookup_access", 32'(plru_access), 32'(ew));
    check("lookup_plru_index", 32'(plru_index), 32'(ix));
    check("lookup_no_mreq", 32'(mem_req_valid), 32'd0);
    @(posedge clk); #1;

    if (!eh) begin
      for (int c = 0; c <= mstall; c++) begin
        mem_req_ready  = (c == mstall);
        mem_resp_valid = (c < mstall) ? 1'($urandom) : 1'b0;
        @(negedge clk);
        check("mreq_valid", 32'(mem_req_valid), 32'd1);
        check("mreq_tag", 32'(mem_req_tag), 32'(t));
        check("mreq_index", 32'(mem_req_index), 32'(ix));
        check("mreq_no_touch", 32'(plru_touch), 32'd0);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0;
      for (int c = 0; c <= wdly; c++) begin
        mem_resp_valid = (c == wdly);
        @(negedge clk);
        check("mwait_mreq_low", 32'(mem_req_valid), 32'd0);
        check("mwait_touch", 32'(plru_touch), 32'(c == wdly));
        if (c == wdly) check("mwait_access", 32'(plru_access), 32'(ew));
        @(posedge clk); #1;
      end
      mem_resp_valid = 1'b0;
    end

    for (int c = 0; c <= rstall; c++) begin
      resp_ready     = (c == rstall);
      mem_resp_valid = 1'($urandom);
      @(negedge clk);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_hit", 32'(resp_hit), 32'(eh));
      check("resp_way", 32'(resp_way), 32'(ew));
      check("resp_no_touch", 32'(plru_touch), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    check("idle_resp_low", 32'(resp_valid), 32'd0);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("touch_once", 32'(touch_cnt - tc0), 32'd1);

    if (!eh) begin
      m_valid[ix][ew] = 1'b1;
      m_tag[ix][ew]   = t;
    end
    m_plru[ix] = plru_upd(m_plru[ix], ew);
    last_hit = eh;
    last_way = ew;
    $display("req tag=%02h set=%0d hit=%0d way=%0d", t, ix, eh, ew);
  endtask

  initial begin
    int tc0;
    rst = 1'b1; plru_clr = 1'b1;
    req_valid = 1'b0; req_tag = 8'd0; req_index = 4'd0; flush = 1'b0;
    resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) m_plru[i] = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; plru_clr = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_plru_touch", 32'(plru_touch), 32'd0);
    check("rst_plru_access", 32'(plru_access), 32'd0);
    check("rst_resp_hit", 32'(resp_hit), 32'd0);
    check("rst_resp_way", 32'(resp_way), 32'd0);

    // First miss, then hit on the same line.
    do_req(8'h12, 4'd3, 0, 0, 0);
    check("first_miss_hit", 32'(last_hit), 32'd0);
    check("first_miss_way", 32'(last_way), 32'd0);
    do_req(8'h12, 4'd3, 0, 0, 0);
    check("repeat_hit", 32'(last_hit), 32'd1);
    check("repeat_way", 32'(last_way), 32'd0);

    // Fill set 5, then evict via the tree.
    for (int i = 0; i < 4; i++) begin
      do_req(8'hA0 + 8'(i), 4'd5, 0, 0, 0);
      check("fill_way", 32'(last_way), 32'(i));
    end
    repeat (2) @(negedge clk);
    check("fill_tree_state", 32'(env_plru[5]), 32'd7);
    do_req(8'hB0, 4'd5, 1, 0, 1);
    check("evict1_hit", 32'(last_hit), 32'd0);
    check("evict1_way", 32'(last_way), 32'd0);
    do_req(8'hB1, 4'd5, 0, 1, 0);
    check("evict2_way", 32'(last_way), 32'd2);

    // Backpressure on both the memory request and the response.
    do_req(8'h77, 4'd9, 5, 3, 2);

    // Flush beats a simultaneous request.
    tc0 = touch_cnt;
    flush = 1'b1; req_valid = 1'b1; req_tag = 8'h34; req_index = 4'd2;
    #1;
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush_stays_idle", 32'(req_ready), 32'd1);
    check("flush_no_mreq", 32'(mem_req_valid), 32'd0);
    check("flush_no_touch", 32'(touch_cnt - tc0), 32'd0);
    model_clear();
    do_req(8'h12, 4'd3, 0, 0, 0);
    check("post_flush_miss", 32'(last_hit), 32'd0);

    // Reset while waiting for a refill; the late refill must be ignored.
    tc0 = touch_cnt;
    req_valid = 1'b1; req_tag = 8'h55; req_index = 4'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("rstmid_mreq", 32'(mem_req_valid), 32'd1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check("rstmid_in_mwait", 32'(mem_req_valid), 32'd0);
    rst = 1'b1; mem_resp_valid = 1'b1;
    #1;
    check("rstmid_touch_during_rst", 32'(plru_touch), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_touch_after", 32'(plru_touch), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_mreq_low", 32'(mem_req_valid), 32'd0);
    check("rstmid_resp_hit", 32'(resp_hit), 32'd0);
    check("rstmid_resp_way", 32'(resp_way), 32'd0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("rstmid_no_touch", 32'(touch_cnt - tc0), 32'd0);
    model_clear();
    do_req(8'h55, 4'd7, 0, 0, 0);
    check("rstmid_next_miss", 32'(last_hit), 32'd0);
    do_req(8'h12, 4'd3, 0, 0, 0);
    check("rstmid_old_miss", 32'(last_hit), 32'd0);

    // Randomized traffic over a few sets with a small tag pool.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        model_clear();
        $display("flush");
      end
      do_req(8'h10 + 8'($urandom_range(0, 5)), 4'($urandom_range(0, 3)),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
